// File: rtl/deal_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : deal_sequencer                                              |
// | Purpose  : Baccarat card-writing datapath. Deals up to six cards into  |
// |            the player/dealer hand registers in table order, applies    |
// |            the third-card rules, and produces the running hand scores  |
// |            and the registered win flags.                               |
// | Ports    : slow_clock      - sole clock, rising edge                   |
// |            resetb          - asynchronous active-low reset             |
// |            start           - one-cycle pulse, begins a new hand        |
// |            step            - one-cycle pulse, advances deal one action |
// |            ext_card[3:0]   - external card source (DEAL_EXT_CARD_EN)   |
// |            pcard1..3[3:0]  - player cards (0 = none, 1..13 = rank)     |
// |            dcard1..3[3:0]  - dealer cards, same encoding               |
// |            pscore, dscore  - hand scores 0..9 (combinational)          |
// |            player_win,     - result flags, both high on a tie          |
// |            dealer_win                                                  |
// |            done            - hand complete                             |
// |            busy            - hand in progress                          |
// | Config   : `DEAL_EXT_CARD_EN - replaces the internal rank counter with |
// |            the ext_card input; out-of-range ranks make step a no-op.   |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module deal_sequencer (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic       start,
  input  logic       step,
`ifdef DEAL_EXT_CARD_EN
  input  logic [3:0] ext_card,
`endif
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic       player_win,
  output logic       dealer_win,
  output logic       done,
  output logic       busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_P1      = 3'd1;
  localparam logic [2:0] S_D1      = 3'd2;
  localparam logic [2:0] S_P2      = 3'd3;
  localparam logic [2:0] S_D2      = 3'd4;
  localparam logic [2:0] S_DECIDE  = 3'd5;
  localparam logic [2:0] S_BANKER3 = 3'd6;
  localparam logic [2:0] S_DONE    = 3'd7;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [3:0] card_src;
  logic       src_valid;
  logic       ld_p1, ld_p2, ld_p3, ld_d1, ld_d2, ld_d3;
  logic       enter_done;
  logic [3:0] dscore_final;

  // Rank -> baccarat value: face value for 1..9, zero for 10..13 and empty.
  function automatic logic [3:0] card_value(input logic [3:0] rank);
    card_value = (rank >= 4'd1 && rank <= 4'd9) ? rank : 4'd0;
  endfunction

  // Full 6-bit sum (max 27) reduced mod 10 without truncating first.
  function automatic logic [3:0] hand_score(input logic [3:0] c1,
                                            input logic [3:0] c2,
                                            input logic [3:0] c3);
    logic [5:0] sum;
    sum = {2'b00, card_value(c1)} + {2'b00, card_value(c2)}
        + {2'b00, card_value(c3)};
    if (sum >= 6'd20)
      hand_score = 4'(sum - 6'd20);
    else if (sum >= 6'd10)
      hand_score = 4'(sum - 6'd10);
    else
      hand_score = sum[3:0];
  endfunction

  // Banker third-card rule, indexed by banker score and player third value.
  function automatic logic banker_draws(input logic [3:0] bs,
                                        input logic [3:0] v);
    case (bs)
      4'd0, 4'd1, 4'd2: banker_draws = 1'b1;
      4'd3:             banker_draws = (v != 4'd8);
      4'd4:             banker_draws = (v >= 4'd2) && (v <= 4'd7);
      4'd5:             banker_draws = (v >= 4'd4) && (v <= 4'd7);
      4'd6:             banker_draws = (v >= 4'd6) && (v <= 4'd7);
      default:          banker_draws = 1'b0;
    endcase
  endfunction

`ifdef DEAL_EXT_CARD_EN
  assign card_src  = ext_card;
  assign src_valid = (ext_card >= 4'd1) && (ext_card <= 4'd13);
`else
  // Free-running rank source 1..13; a step captures its pre-edge value.
  logic [3:0] counter;

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb)
      counter <= 4'd1;
    else if (counter == 4'd13)
      counter <= 4'd1;
    else
      counter <= counter + 4'd1;
  end

  assign card_src  = counter;
  assign src_valid = 1'b1;
`endif

  assign pscore = hand_score(pcard1, pcard2, pcard3);
  assign dscore = hand_score(dcard1, dcard2, dcard3);

  always_comb begin
    state_nxt = state;
    ld_p1     = 1'b0;
    ld_p2     = 1'b0;
    ld_p3     = 1'b0;
    ld_d1     = 1'b0;
    ld_d2     = 1'b0;
    ld_d3     = 1'b0;
    if (start) begin
      state_nxt = S_P1;
    end else if (step && src_valid) begin
      case (state)
        S_P1: begin ld_p1 = 1'b1; state_nxt = S_D1;     end
        S_D1: begin ld_d1 = 1'b1; state_nxt = S_P2;     end
        S_P2: begin ld_p2 = 1'b1; state_nxt = S_D2;     end
        S_D2: begin ld_d2 = 1'b1; state_nxt = S_DECIDE; end
        S_DECIDE: begin
          if (pscore >= 4'd8 || dscore >= 4'd8) begin
            state_nxt = S_DONE;
          end else if (pscore <= 4'd5) begin
            ld_p3     = 1'b1;
            state_nxt = S_BANKER3;
          end else begin
            ld_d3     = (dscore <= 4'd5);
            state_nxt = S_DONE;
          end
        end
        S_BANKER3: begin
          ld_d3     = banker_draws(dscore, card_value(pcard3));
          state_nxt = S_DONE;
        end
        default: state_nxt = state;
      endcase
    end
  end

  // Win flags are registered on the same edge that may load dcard3, so the
  // comparison must use the dealer score including that incoming card.
  assign enter_done   = (state_nxt == S_DONE) && (state != S_DONE);
  assign dscore_final = hand_score(dcard1, dcard2, ld_d3 ? card_src : dcard3);

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state      <= S_IDLE;
      pcard1     <= 4'd0;
      pcard2     <= 4'd0;
      pcard3     <= 4'd0;
      dcard1     <= 4'd0;
      dcard2     <= 4'd0;
      dcard3     <= 4'd0;
      player_win <= 1'b0;
      dealer_win <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        pcard1     <= 4'd0;
        pcard2     <= 4'd0;
        pcard3     <= 4'd0;
        dcard1     <= 4'd0;
        dcard2     <= 4'd0;
        dcard3     <= 4'd0;
        player_win <= 1'b0;
        dealer_win <= 1'b0;
        done       <= 1'b0;
        busy       <= 1'b1;
      end else begin
        if (ld_p1) pcard1 <= card_src;
        if (ld_p2) pcard2 <= card_src;
        if (ld_p3) pcard3 <= card_src;
        if (ld_d1) dcard1 <= card_src;
        if (ld_d2) dcard2 <= card_src;
        if (ld_d3) dcard3 <= card_src;
        if (enter_done) begin
          done       <= 1'b1;
          busy       <= 1'b0;
          player_win <= (pscore >= dscore_final);
          dealer_win <= (dscore_final >= pscore);
        end
      end
    end
  end

endmodule
`default_nettype wire
